// File: rtl/ram_ctrl_pkg.sv
// ============================================================================
// ram_ctrl_pkg
//   Shared geometry constants and FSM state encoding for the RAM controller.
//   Optional VERIFY state exists only when RAM_CTRL_VERIFY_EN is defined.
//   Revision: 1.0
// ============================================================================
`default_nettype none

package ram_ctrl_pkg;

    localparam int c_ADDR_W = 3;
    localparam int c_DATA_W = 8;
    localparam int c_DEPTH  = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_READ   = 3'd2,
`ifdef RAM_CTRL_VERIFY_EN
        ST_VERIFY = 3'd4,
`endif
        ST_FILL   = 3'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/ram_8x8_ctrl.sv
// ============================================================================
// ram_8x8_ctrl
//   Single-port RAM controller: host read/write requests plus whole-memory fill.
//   Define RAM_CTRL_VERIFY_EN to add a read-back verify cycle after each write.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module ram_8x8_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W,
    parameter int DEPTH  = c_DEPTH
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_pattern,
    output logic              fill_done,
    output logic              ram_rw,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              verify_err
);

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t              r_state,     w_state_nxt;
    logic                r_ram_rw,    w_ram_rw_nxt;
    logic [ADDR_W-1:0]   r_ram_addr,  w_ram_addr_nxt;
    logic [DATA_W-1:0]   r_ram_din,   w_ram_din_nxt;
    logic [ADDR_W-1:0]   r_fill_cnt,  w_fill_cnt_nxt;
    logic                r_rsp_valid, w_rsp_valid_nxt;
    logic [DATA_W-1:0]   r_rsp_data,  w_rsp_data_nxt;
    logic                r_fill_done, w_fill_done_nxt;
    logic                w_req_ready;
`ifdef RAM_CTRL_VERIFY_EN
    logic                r_verify_err, w_verify_err_nxt;
`endif

    // Fill takes priority over a simultaneous host request.
    assign w_req_ready = (r_state == ST_IDLE) && !fill_start;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state      <= ST_IDLE;
            r_ram_rw     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_din    <= '0;
            r_fill_cnt   <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_fill_done  <= 1'b0;
`ifdef RAM_CTRL_VERIFY_EN
            r_verify_err <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_ram_rw     <= w_ram_rw_nxt;
            r_ram_addr   <= w_ram_addr_nxt;
            r_ram_din    <= w_ram_din_nxt;
            r_fill_cnt   <= w_fill_cnt_nxt;
            r_rsp_valid  <= w_rsp_valid_nxt;
            r_rsp_data   <= w_rsp_data_nxt;
            r_fill_done  <= w_fill_done_nxt;
`ifdef RAM_CTRL_VERIFY_EN
            r_verify_err <= w_verify_err_nxt;
`endif
        end
    end

    // RAM-side outputs are computed one cycle ahead so they leave the block registered.
    always_comb begin
        w_state_nxt      = r_state;
        w_ram_rw_nxt     = 1'b0;
        w_ram_addr_nxt   = r_ram_addr;
        w_ram_din_nxt    = r_ram_din;
        w_fill_cnt_nxt   = r_fill_cnt;
        w_rsp_valid_nxt  = 1'b0;
        w_rsp_data_nxt   = r_rsp_data;
        w_fill_done_nxt  = 1'b0;
`ifdef RAM_CTRL_VERIFY_EN
        w_verify_err_nxt = r_verify_err;
`endif
        unique case (r_state)
            ST_IDLE: begin
                if (fill_start) begin
                    w_state_nxt    = ST_FILL;
                    w_ram_rw_nxt   = 1'b1;
                    w_ram_addr_nxt = '0;
                    w_ram_din_nxt  = fill_pattern;
                    w_fill_cnt_nxt = '0;
                end else if (req_valid && w_req_ready) begin
                    w_ram_addr_nxt = req_addr;
                    if (req_we) begin
                        w_state_nxt   = ST_WRITE;
                        w_ram_rw_nxt  = 1'b1;
                        w_ram_din_nxt = req_wdata;
                    end else begin
                        w_state_nxt   = ST_READ;
                    end
                end
            end
            ST_WRITE: begin
`ifdef RAM_CTRL_VERIFY_EN
                w_state_nxt = ST_VERIFY;
`else
                w_state_nxt = ST_IDLE;
`endif
            end
`ifdef RAM_CTRL_VERIFY_EN
            ST_VERIFY: begin
                if (ram_dout != r_ram_din) begin
                    w_verify_err_nxt = 1'b1;
                end
                w_state_nxt = ST_IDLE;
            end
`endif
            ST_READ: begin
                w_rsp_valid_nxt = 1'b1;
                w_rsp_data_nxt  = ram_dout;
                w_state_nxt     = ST_IDLE;
            end
            ST_FILL: begin
                // Stop on the last word rather than letting the counter wrap.
                if (r_fill_cnt == c_LAST_ADDR) begin
                    w_state_nxt     = ST_IDLE;
                    w_fill_done_nxt = 1'b1;
                end else begin
                    w_fill_cnt_nxt  = r_fill_cnt + 1'b1;
                    w_ram_addr_nxt  = r_fill_cnt + 1'b1;
                    w_ram_rw_nxt    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign req_ready = w_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign fill_done = r_fill_done;
    assign ram_rw    = r_ram_rw;
    assign ram_addr  = r_ram_addr;
    assign ram_din   = r_ram_din;
`ifdef RAM_CTRL_VERIFY_EN
    assign verify_err = r_verify_err;
`else
    assign verify_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ram_8x8_ctrl.sv
// ============================================================================
// tb_ram_8x8_ctrl
//   Directed self-checking bench for ram_8x8_ctrl with a behavioural RAM model.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ram_8x8_ctrl;

    logic       clk;
    logic       clr;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [2:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       fill_start;
    logic [7:0] fill_pattern;
    logic       fill_done;
    logic       ram_rw;
    logic [2:0] ram_addr;
    logic [7:0] ram_din;
    logic [7:0] ram_dout;
    logic       verify_err;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] mem [0:7];
    logic       r_stuck;

    ram_8x8_ctrl u_dut (
        .clk          (clk),
        .clr          (clr),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .fill_start   (fill_start),
        .fill_pattern (fill_pattern),
        .fill_done    (fill_done),
        .ram_rw       (ram_rw),
        .ram_addr     (ram_addr),
        .ram_din      (ram_din),
        .ram_dout     (ram_dout),
        .verify_err   (verify_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-write, asynchronous-read RAM; r_stuck models bit 0 stuck at 0.
    always @(posedge clk) begin
        if (ram_rw) mem[ram_addr] <= r_stuck ? (ram_din & 8'hFE) : ram_din;
    end
    assign ram_dout = mem[ram_addr];

    task automatic do_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
`ifdef RAM_CTRL_VERIFY_EN
        @(negedge clk);
`endif
    endtask

    task automatic do_read(input logic [2:0] a, output logic v, output logic [7:0] d);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = a;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        v = rsp_valid;
        d = rsp_data;
    endtask

    task automatic test_reset;
        #2;
        n_total++; if (ram_rw !== 1'b0)     $display("FAIL rst_ram_rw: got %b want 0", ram_rw); else n_pass++;
        n_total++; if (ram_addr !== 3'd0)   $display("FAIL rst_ram_addr: got %h want 0", ram_addr); else n_pass++;
        n_total++; if (ram_din !== 8'h00)   $display("FAIL rst_ram_din: got %h want 00", ram_din); else n_pass++;
        n_total++; if (rsp_valid !== 1'b0)  $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
        n_total++; if (rsp_data !== 8'h00)  $display("FAIL rst_rsp_data: got %h want 00", rsp_data); else n_pass++;
        n_total++; if (fill_done !== 1'b0)  $display("FAIL rst_fill_done: got %b want 0", fill_done); else n_pass++;
        n_total++; if (verify_err !== 1'b0) $display("FAIL rst_verify_err: got %b want 0", verify_err); else n_pass++;
        n_total++; if (req_ready !== 1'b1)  $display("FAIL rst_req_ready: got %b want 1", req_ready); else n_pass++;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_write_read;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd3; req_wdata = 8'hA5;
        #1;
        n_total++; if (req_ready !== 1'b1) $display("FAIL wr_ready: got %b want 1", req_ready); else n_pass++;
        @(negedge clk);
        req_valid = 1'b0;
        n_total++; if (ram_rw !== 1'b1)   $display("FAIL wr_rw: got %b want 1", ram_rw); else n_pass++;
        n_total++; if (ram_addr !== 3'd3) $display("FAIL wr_addr: got %h want 3", ram_addr); else n_pass++;
        n_total++; if (ram_din !== 8'hA5) $display("FAIL wr_din: got %h want a5", ram_din); else n_pass++;
        n_total++; if (req_ready !== 1'b0) $display("FAIL wr_busy: got %b want 0", req_ready); else n_pass++;
        @(negedge clk);
        n_total++; if (ram_rw !== 1'b0)   $display("FAIL wr_rw_end: got %b want 0", ram_rw); else n_pass++;
`ifdef RAM_CTRL_VERIFY_EN
        n_total++; if (ram_addr !== 3'd3) $display("FAIL vf_addr: got %h want 3", ram_addr); else n_pass++;
        n_total++; if (req_ready !== 1'b0) $display("FAIL vf_busy: got %b want 0", req_ready); else n_pass++;
        @(negedge clk);
`else
        n_total++; if (req_ready !== 1'b1) $display("FAIL wr_idle: got %b want 1", req_ready); else n_pass++;
`endif
        req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd3;
        @(negedge clk);
        req_valid = 1'b0;
        n_total++; if (ram_rw !== 1'b0)    $display("FAIL rd_rw: got %b want 0", ram_rw); else n_pass++;
        n_total++; if (ram_addr !== 3'd3)  $display("FAIL rd_addr: got %h want 3", ram_addr); else n_pass++;
        n_total++; if (rsp_valid !== 1'b0) $display("FAIL rd_early: got %b want 0", rsp_valid); else n_pass++;
        @(negedge clk);
        n_total++; if (rsp_valid !== 1'b1) $display("FAIL rd_valid: got %b want 1", rsp_valid); else n_pass++;
        n_total++; if (rsp_data !== 8'hA5) $display("FAIL rd_data: got %h want a5", rsp_data); else n_pass++;
        @(negedge clk);
        n_total++; if (rsp_valid !== 1'b0) $display("FAIL rd_pulse: got %b want 0", rsp_valid); else n_pass++;
        n_total++; if (rsp_data !== 8'hA5) $display("FAIL rd_hold: got %h want a5", rsp_data); else n_pass++;
        n_total++; if (verify_err !== 1'b0) $display("FAIL wr_verr: got %b want 0", verify_err); else n_pass++;
    endtask

    task automatic test_fill;
        logic       v;
        logic [7:0] d;
        @(negedge clk);
        fill_start = 1'b1; fill_pattern = 8'h3C;
        #1;
        n_total++; if (req_ready !== 1'b0) $display("FAIL fill_ready: got %b want 0", req_ready); else n_pass++;
        @(negedge clk);
        fill_start = 1'b0; fill_pattern = 8'h00;
        for (int i = 0; i < 8; i++) begin
            n_total++; if (ram_rw !== 1'b1) $display("FAIL fill_rw[%0d]: got %b want 1", i, ram_rw); else n_pass++;
            n_total++; if (ram_addr !== 3'(i)) $display("FAIL fill_addr[%0d]: got %h want %h", i, ram_addr, 3'(i)); else n_pass++;
            n_total++; if (ram_din !== 8'h3C) $display("FAIL fill_din[%0d]: got %h want 3c", i, ram_din); else n_pass++;
            n_total++; if (fill_done !== 1'b0) $display("FAIL fill_early_done[%0d]: got %b want 0", i, fill_done); else n_pass++;
            @(negedge clk);
        end
        n_total++; if (fill_done !== 1'b1) $display("FAIL fill_done: got %b want 1", fill_done); else n_pass++;
        n_total++; if (ram_rw !== 1'b0)    $display("FAIL fill_rw_end: got %b want 0", ram_rw); else n_pass++;
        @(negedge clk);
        n_total++; if (fill_done !== 1'b0) $display("FAIL fill_done_pulse: got %b want 0", fill_done); else n_pass++;
        do_read(3'd0, v, d);
        n_total++; if (v !== 1'b1 || d !== 8'h3C) $display("FAIL fill_rd0: got v=%b d=%h want v=1 d=3c", v, d); else n_pass++;
        do_read(3'd7, v, d);
        n_total++; if (v !== 1'b1 || d !== 8'h3C) $display("FAIL fill_rd7: got v=%b d=%h want v=1 d=3c", v, d); else n_pass++;
    endtask

    task automatic test_fill_priority;
        logic       v;
        logic [7:0] d;
        do_write(3'd1, 8'h11);
        @(negedge clk);
        fill_start = 1'b1; fill_pattern = 8'h3C;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd1; req_wdata = 8'hFF;
        #1;
        n_total++; if (req_ready !== 1'b0) $display("FAIL prio_ready: got %b want 0", req_ready); else n_pass++;
        @(negedge clk);
        fill_start = 1'b0; req_valid = 1'b0;
        n_total++; if (ram_addr !== 3'd0 || ram_din !== 8'h3C) $display("FAIL prio_fill: got a=%h d=%h want a=0 d=3c", ram_addr, ram_din); else n_pass++;
        repeat (8) @(negedge clk);
        n_total++; if (fill_done !== 1'b1) $display("FAIL prio_done: got %b want 1", fill_done); else n_pass++;
        do_read(3'd1, v, d);
        n_total++; if (v !== 1'b1 || d !== 8'h3C) $display("FAIL prio_rd1: got v=%b d=%h want v=1 d=3c", v, d); else n_pass++;
    endtask

    task automatic test_fill_abort;
        logic       v;
        logic [7:0] d;
        do_write(3'd5, 8'h55);
        do_write(3'd6, 8'h66);
        do_write(3'd7, 8'h77);
        do_read(3'd6, v, d);
        @(negedge clk);
        fill_start = 1'b1; fill_pattern = 8'hC3;
        @(negedge clk);
        fill_start = 1'b0;
        repeat (4) @(negedge clk);
        n_total++; if (ram_addr !== 3'd4 || ram_rw !== 1'b1) $display("FAIL abort_at4: got a=%h rw=%b want a=4 rw=1", ram_addr, ram_rw); else n_pass++;
        clr = 1'b1;
        #1;
        n_total++; if (ram_rw !== 1'b0)    $display("FAIL abort_rw: got %b want 0", ram_rw); else n_pass++;
        n_total++; if (ram_addr !== 3'd0)  $display("FAIL abort_addr: got %h want 0", ram_addr); else n_pass++;
        n_total++; if (ram_din !== 8'h00)  $display("FAIL abort_din: got %h want 00", ram_din); else n_pass++;
        n_total++; if (rsp_data !== 8'h00) $display("FAIL abort_rsp_data: got %h want 00", rsp_data); else n_pass++;
        n_total++; if (req_ready !== 1'b1) $display("FAIL abort_ready: got %b want 1", req_ready); else n_pass++;
        @(negedge clk);
        clr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_total++; if (fill_done !== 1'b0 || ram_rw !== 1'b0) $display("FAIL abort_quiet[%0d]: got done=%b rw=%b want 0 0", i, fill_done, ram_rw); else n_pass++;
        end
        do_read(3'd5, v, d);
        n_total++; if (d !== 8'h55) $display("FAIL abort_rd5: got %h want 55", d); else n_pass++;
        do_read(3'd6, v, d);
        n_total++; if (d !== 8'h66) $display("FAIL abort_rd6: got %h want 66", d); else n_pass++;
        do_read(3'd7, v, d);
        n_total++; if (d !== 8'h77) $display("FAIL abort_rd7: got %h want 77", d); else n_pass++;
        do_read(3'd3, v, d);
        n_total++; if (d !== 8'hC3) $display("FAIL abort_rd3: got %h want c3", d); else n_pass++;
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 8; i++) do_write(3'(i), 8'hA0 + 8'(i));
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            req_addr = 3'(i);
            #1;
            n_total++; if (req_ready !== 1'b1) $display("FAIL b2b_ready[%0d]: got %b want 1", i, req_ready); else n_pass++;
            @(negedge clk);
            n_total++; if (req_ready !== 1'b0 || ram_addr !== 3'(i)) $display("FAIL b2b_busy[%0d]: got rdy=%b a=%h want 0 %h", i, req_ready, ram_addr, 3'(i)); else n_pass++;
            @(negedge clk);
            n_total++; if (rsp_valid !== 1'b1 || rsp_data !== 8'hA0 + 8'(i)) $display("FAIL b2b_rsp[%0d]: got v=%b d=%h want 1 %h", i, rsp_valid, rsp_data, 8'hA0 + 8'(i)); else n_pass++;
        end
        req_valid = 1'b0;
    endtask

    task automatic test_verify;
`ifdef RAM_CTRL_VERIFY_EN
        r_stuck = 1'b1;
        do_write(3'd2, 8'h01);
        r_stuck = 1'b0;
        n_total++; if (verify_err !== 1'b1) $display("FAIL verr_set: got %b want 1", verify_err); else n_pass++;
        do_write(3'd4, 8'h22);
        do_write(3'd5, 8'h44);
        n_total++; if (verify_err !== 1'b1) $display("FAIL verr_sticky: got %b want 1", verify_err); else n_pass++;
        @(negedge clk);
        clr = 1'b1;
        #1;
        n_total++; if (verify_err !== 1'b0) $display("FAIL verr_clr: got %b want 0", verify_err); else n_pass++;
        @(negedge clk);
        clr = 1'b0;
`else
        do_write(3'd2, 8'h01);
        n_total++; if (verify_err !== 1'b0) $display("FAIL verr_tied: got %b want 0", verify_err); else n_pass++;
`endif
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        r_stuck      = 1'b0;
        clr          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = 3'd0;
        req_wdata    = 8'h00;
        fill_start   = 1'b0;
        fill_pattern = 8'h00;
        test_reset();
        test_write_read();
        test_fill();
        test_fill_priority();
        test_fill_abort();
        test_back_to_back();
        test_verify();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
